me_scan_controller: RTL
=======================

Name: me_scan_controller

Overview:
- Sequences the motion-estimation datapath: walks every candidate vector (mx,my in 0..15) over a 32x32 search window for one 16x16 reference block.
- Generates AddressR/AddressS1/AddressS2 plus control strobes for a dual-lane SAD (PE) pair. Lane 1 computes candidate mx even, lane 2 computes mx+1.
- Collects per-pair distances, tracks the best vector, and raises completed.
- Sits between the testbench-loaded reference/search memories and the PE pair.

Parameters:
- MEM_LAT, 1, read latency in cycles from address to R/S1/S2 data valid (1..3).
- PE_TIMEOUT, 16, max cycles to wait for dist_valid after pe_last before flagging error.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; begins a full search (honoured in IDLE or DONE only)
- AddressR  out  8  reference memory address = i*16 + j
- AddressS1  out  10  search address, lane 1 = (my+i)*32 + mx + j
- AddressS2  out  10  search address, lane 2 = AddressS1 + 1
- pe_clear  out  1  asserted with first aligned pixel (i=j=0) of a candidate pair
- pe_accum  out  1  asserted on every aligned pixel cycle (256 per pair)
- pe_last  out  1  asserted with aligned pixel i=j=15
- dist_valid  in  1  PE pair result strobe
- dist1  in  8  lane-1 saturated SAD
- dist2  in  8  lane-2 saturated SAD
- bestDistance  out  8  best SAD found
- motionX  out  4  best mx
- motionY  out  4  best my
- completed  out  1  search finished; held until next start or reset
- busy  out  1  high in any state except IDLE and DONE
- error  out  1  sticky PE timeout flag; cleared by start or reset

Behaviour:
- Reset (async, active-high): FSM to IDLE; all addresses 0; pe_* 0; bestDistance 0; motionX/Y 0; completed 0; busy 0; error 0; delay pipe flushed.
- FSM states: IDLE, SCAN, WAIT, UPDATE, DONE.
- IDLE/DONE + start -> SCAN. Clears completed and error, zeroes counters (j, i, pair p, my) and sets first_result flag.
- SCAN: one address per cycle, 256 cycles per pair.
  - j increments every cycle; i increments on j wrap; mx = 2p.
  - Last address (i=j=15) -> WAIT.
- Control strobes pass through a MEM_LAT-deep delay pipe so they align with memory data.
  - pe_clear first aligns MEM_LAT cycles after SCAN entry.
- WAIT: counts cycles from aligned pe_last.
  - dist_valid -> UPDATE, with dist1/dist2 latched.
  - PE_TIMEOUT reached without dist_valid: set error, go to DONE with completed=1; best values are those so far.
  - dist_valid outside WAIT is ignored.
- UPDATE (1 cycle), compared in order:
  1. Lane 1: if first_result OR dist1 < best, load (dist1, mx, my) and clear first_result.
  2. Lane 2: if dist2 < best (after the lane-1 update), load (dist2, mx+1, my).
  - Strict less-than: earlier scan order wins ties; lane 1 beats lane 2 on equal.
  - Next: p++; on p wrap (8 pairs) my++. After pair (p=7, my=15) -> DONE, else -> SCAN.
- DONE: completed=1, busy=0; outputs hold.
- start while busy: ignored.
- Reset mid-scan: immediate IDLE, no result retained.
- Cycle count per pair = 256 + MEM_LAT + PE latency + 2 (WAIT entry + UPDATE). A full search is 128 pairs.
- Addresses are held at their last value outside SCAN.

Optional Feature:
- Macro: ME_EARLY_EXIT_EN.
- Defined: after UPDATE, if bestDistance == 0, go directly to DONE (completed=1) and skip the remaining candidates.
- Undefined: all 128 pairs are always scanned; a zero distance found early is kept through strict less-than.

Decomposition:
- Package me_pkg:
  - state enum me_state_t {IDLE, SCAN, WAIT, UPDATE, DONE}
  - constants BLK_DIM=16, SRCH_DIM=32, NUM_PAIRS=8, RMEM_MAX=256, SMEM_MAX=1024
- Sub-module me_addr_gen: i/j/p/my counters and address arithmetic.
  - Inputs: advance, clear.
  - Outputs: AddressR/S1/S2, first_pix, last_pix, last_pair.
- Top holds the FSM, delay pipe, best tracker and timeout.

Test Plan:
- Search memory = reference block copied at offset (mx=5, my=3), other pixels random; bench PE model computes SAD -> motionX=5, motionY=3, bestDistance=0, completed=1 after full scan (early exit disabled).
- Identical minimum distance 10 at (2,0) and (3,0) -> motionX=2 (lane-1 tie win); at (4,1) and (2,6) -> (4,1) (earlier scan wins).
- All dist1/dist2 = 8'hFF -> motionX=0, motionY=0, bestDistance=FF (first_result load).
- Assert reset at scan cycle 1000, then start -> busy falls immediately, outputs return to reset values, second search completes correctly.
- PE model withholds dist_valid for one pair -> error=1, completed=1 after PE_TIMEOUT=16 cycles; next start clears error.
- ME_EARLY_EXIT_EN defined, zero match at (1,0) -> completed after exactly 1 pair (pair 0), motionX=1.

Source files
------------

// File: rtl/me_pkg.sv
// ----------------------------------------------------------------------------
// me_pkg
// Shared types and constants for the motion-estimation scan controller.
//   me_state_t : controller FSM states
//   pe_ctl_t   : PE control strobe bundle carried through the memory-latency
//                delay pipe
//   srch_addr  : row/column to linear search-window address
// ----------------------------------------------------------------------------
package me_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    WAIT,
    UPDATE,
    DONE
  } me_state_t;

  typedef struct packed {
    logic clear;
    logic accum;
    logic last;
  } pe_ctl_t;

  localparam int BLK_DIM   = 16;
  localparam int SRCH_DIM  = 32;
  localparam int NUM_PAIRS = 8;
  localparam int RMEM_MAX  = 256;
  localparam int SMEM_MAX  = 1024;

  // Window rows are SRCH_DIM (32) wide, so row*32 + col is a plain concat.
  function automatic logic [9:0] srch_addr(input logic [4:0] row,
                                           input logic [4:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/me_addr_gen.sv
// ----------------------------------------------------------------------------
// me_addr_gen
// Pixel (j, i), pair (p) and row (my) counters for the candidate scan, plus
// registered reference / search addresses derived from them.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   i_clear          : zero all counters (new search)
//   i_advance        : step to the next pixel of the current pair
//   i_next_pair      : step to pixel (0,0) of the next candidate pair
//   o_addr_r         : reference address  i*16 + j
//   o_addr_s1/s2     : search addresses   (my+i)*32 + 2p + j, and +1
//   o_mx, o_my       : lane-1 candidate vector of the current pair
//   o_first_pix      : current pixel is i=j=0
//   o_last_pix       : current pixel is i=j=15
//   o_last_pair      : current pair is p=7, my=15
// ----------------------------------------------------------------------------
module me_addr_gen
  import me_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clear,
  input  logic       i_advance,
  input  logic       i_next_pair,
  output logic [7:0] o_addr_r,
  output logic [9:0] o_addr_s1,
  output logic [9:0] o_addr_s2,
  output logic [3:0] o_mx,
  output logic [3:0] o_my,
  output logic       o_first_pix,
  output logic       o_last_pix,
  output logic       o_last_pair
);

  localparam logic [3:0] LAST_IDX  = 4'(BLK_DIM - 1);
  localparam logic [2:0] LAST_PAIR = 3'(NUM_PAIRS - 1);

  logic [3:0] r_j, r_i, r_my;
  logic [2:0] r_p;
  logic [7:0] r_addr_r;
  logic [9:0] r_addr_s1, r_addr_s2;

  logic [3:0] w_j, w_i, w_my;
  logic [2:0] w_p;
  logic [4:0] w_row, w_col;
  logic [9:0] w_s1;
  logic       w_step;

  // NOTE: every variable gets a default before any branch, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    w_j  = r_j;
    w_i  = r_i;
    w_p  = r_p;
    w_my = r_my;
    if (i_clear) begin
      w_j  = '0;
      w_i  = '0;
      w_p  = '0;
      w_my = '0;
    end else if (i_next_pair) begin
      w_j = '0;
      w_i = '0;
      w_p = r_p + 3'd1;
      if (r_p == LAST_PAIR) w_my = r_my + 4'd1;
    end else if (i_advance) begin
      w_j = r_j + 4'd1;
      if (r_j == LAST_IDX) w_i = r_i + 4'd1;
    end
  end

  assign w_step = i_clear | i_next_pair | i_advance;
  assign w_row  = {1'b0, w_my} + {1'b0, w_i};
  assign w_col  = {1'b0, w_p, 1'b0} + {1'b0, w_j};
  assign w_s1   = srch_addr(w_row, w_col);

  // Addresses are registered from the next-counter values so they move in
  // lockstep with the counters, read 0 out of reset, and hold while idle.
  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_j       <= '0;
      r_i       <= '0;
      r_p       <= '0;
      r_my      <= '0;
      r_addr_r  <= '0;
      r_addr_s1 <= '0;
      r_addr_s2 <= '0;
    end else if (w_step) begin
      r_j       <= w_j;
      r_i       <= w_i;
      r_p       <= w_p;
      r_my      <= w_my;
      r_addr_r  <= {w_i, w_j};
      r_addr_s1 <= w_s1;
      r_addr_s2 <= w_s1 + 10'd1;
    end
  end

  assign o_addr_r    = r_addr_r;
  assign o_addr_s1   = r_addr_s1;
  assign o_addr_s2   = r_addr_s2;
  assign o_mx        = {r_p, 1'b0};
  assign o_my        = r_my;
  assign o_first_pix = (r_i == '0) && (r_j == '0);
  assign o_last_pix  = (r_i == LAST_IDX) && (r_j == LAST_IDX);
  assign o_last_pair = (r_p == LAST_PAIR) && (r_my == LAST_IDX);

endmodule

// File: rtl/me_scan_controller.sv
// ----------------------------------------------------------------------------
// me_scan_controller
// Walks all 256 candidate vectors (mx,my in 0..15) of a 32x32 search window
// for one 16x16 reference block, two candidates (mx, mx+1) per pass, drives
// a dual-lane SAD PE pair and keeps the best vector.
// Ports:
//   clk, reset, start           : clock, async active-high reset, go pulse
//   AddressR/AddressS1/AddressS2: reference / lane-1 / lane-2 addresses
//   pe_clear/pe_accum/pe_last   : PE strobes, aligned with memory data
//   dist_valid, dist1, dist2    : PE pair result
//   bestDistance, motionX/Y     : best SAD and its vector
//   completed, busy, error      : status (error = sticky PE timeout)
// Parameters: MEM_LAT (1..3) memory read latency, PE_TIMEOUT result wait.
// Build option: define ME_EARLY_EXIT_EN to stop as soon as the best SAD is 0.
// ----------------------------------------------------------------------------
module me_scan_controller
  import me_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int PE_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [7:0] AddressR,
  output logic [9:0] AddressS1,
  output logic [9:0] AddressS2,
  output logic       pe_clear,
  output logic       pe_accum,
  output logic       pe_last,
  input  logic       dist_valid,
  input  logic [7:0] dist1,
  input  logic [7:0] dist2,
  output logic [7:0] bestDistance,
  output logic [3:0] motionX,
  output logic [3:0] motionY,
  output logic       completed,
  output logic       busy,
  output logic       error
);

  localparam int              CNT_W       = $clog2(PE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(PE_TIMEOUT);

  me_state_t  r_state, w_state_next;
  pe_ctl_t    r_pipe [MEM_LAT];
  pe_ctl_t    w_ctl, w_pe;

  logic       w_clear, w_advance, w_next_pair, w_timeout, w_early;
  logic       w_first_pix, w_last_pix, w_last_pair;
  logic [3:0] w_cur_mx, w_cur_my;

  logic       r_completed, r_error, r_first, r_armed;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [7:0] r_d1, r_d2, r_best;
  logic [3:0] r_bmx, r_bmy;
  logic [7:0] w_best_next;
  logic [3:0] w_bmx_next, w_bmy_next;

  me_addr_gen u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_clear),
    .i_advance  (w_advance),
    .i_next_pair(w_next_pair),
    .o_addr_r   (AddressR),
    .o_addr_s1  (AddressS1),
    .o_addr_s2  (AddressS2),
    .o_mx       (w_cur_mx),
    .o_my       (w_cur_my),
    .o_first_pix(w_first_pix),
    .o_last_pix (w_last_pix),
    .o_last_pair(w_last_pair)
  );

  // Lane 1 first (first_result forces a load), then lane 2 against the
  // lane-1-updated best; strict less-than keeps the earlier candidate on ties.
  always_comb begin
    w_best_next = r_best;
    w_bmx_next  = r_bmx;
    w_bmy_next  = r_bmy;
    if (r_first || (r_d1 < r_best)) begin
      w_best_next = r_d1;
      w_bmx_next  = w_cur_mx;
      w_bmy_next  = w_cur_my;
    end
    if (r_d2 < w_best_next) begin
      w_best_next = r_d2;
      w_bmx_next  = w_cur_mx | 4'd1;
      w_bmy_next  = w_cur_my;
    end
  end

`ifdef ME_EARLY_EXIT_EN
  assign w_early = (w_best_next == 8'd0);
`else
  assign w_early = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_advance    = 1'b0;
    w_next_pair  = 1'b0;
    w_timeout    = 1'b0;
    unique case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_next = SCAN;
          w_clear      = 1'b1;
        end
      end
      SCAN: begin
        if (w_last_pix) w_state_next = WAIT;
        else            w_advance    = 1'b1;
      end
      WAIT: begin
        if (dist_valid) begin
          w_state_next = UPDATE;
        end else if (r_armed && (r_wait_cnt >= TIMEOUT_CNT)) begin
          w_state_next = DONE;
          w_timeout    = 1'b1;
        end
      end
      UPDATE: begin
        if (w_last_pair || w_early) begin
          w_state_next = DONE;
        end else begin
          w_state_next = SCAN;
          w_next_pair  = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Strobes are issued with the address and delayed by MEM_LAT so the PE
  // sees them in the same cycle as the corresponding pixel data.
  always_comb begin
    w_ctl = '0;
    if (r_state == SCAN) begin
      w_ctl.clear = w_first_pix;
      w_ctl.accum = 1'b1;
      w_ctl.last  = w_last_pix;
    end
  end

  // NOTE: the delay pipe is a handful of flops, not a RAM, so it is reset
  // explicitly; stale strobes after a mid-scan reset would corrupt the PE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < MEM_LAT; k++) r_pipe[k] <= '0;
    end else begin
      r_pipe[0] <= w_ctl;
      for (int k = 1; k < MEM_LAT; k++) r_pipe[k] <= r_pipe[k-1];
    end
  end

  assign w_pe = r_pipe[MEM_LAT-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_completed <= 1'b0;
      r_error     <= 1'b0;
      r_first     <= 1'b0;
      r_armed     <= 1'b0;
      r_wait_cnt  <= '0;
      r_d1        <= '0;
      r_d2        <= '0;
      r_best      <= '0;
      r_bmx       <= '0;
      r_bmy       <= '0;
    end else begin
      r_state <= w_state_next;

      if (w_clear) begin
        r_completed <= 1'b0;
        r_error     <= 1'b0;
        r_first     <= 1'b1;
      end
      if (w_timeout) r_error <= 1'b1;
      if ((w_state_next == DONE) && (r_state != DONE)) r_completed <= 1'b1;

      if ((r_state == WAIT) && dist_valid) begin
        r_d1 <= dist1;
        r_d2 <= dist2;
      end

      if (r_state == UPDATE) begin
        r_best  <= w_best_next;
        r_bmx   <= w_bmx_next;
        r_bmy   <= w_bmy_next;
        r_first <= 1'b0;
      end

      // Timeout count starts at the aligned pe_last and saturates.
      if (r_state != WAIT) begin
        r_armed    <= 1'b0;
        r_wait_cnt <= '0;
      end else if (w_pe.last) begin
        r_armed    <= 1'b1;
        r_wait_cnt <= CNT_W'(1);
      end else if (r_armed && (r_wait_cnt < TIMEOUT_CNT)) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
    end
  end

  assign pe_clear     = w_pe.clear;
  assign pe_accum     = w_pe.accum;
  assign pe_last      = w_pe.last;
  assign bestDistance = r_best;
  assign motionX      = r_bmx;
  assign motionY      = r_bmy;
  assign completed    = r_completed;
  assign error        = r_error;
  assign busy         = (r_state != IDLE) && (r_state != DONE);

endmodule
